phase_gen_multi: RTL and testbench

- Parametrised multi-channel phase/enable generator for the multicycle RISC-V core.
- One free-running period counter drives CH phase outputs; each output is high inside a programmable [rise, fall) window of the period.
- Replaces fixed-divider phase generation with runtime-programmable windows, shadowed config that takes effect at period boundaries, and run, single-step and drain modes.
- Sits between the board clock and the ALU/RAM/regfile enable inputs.

---
 rtl/phase_gen_multi.sv | 139 +++++++++++++
 tb/tb_phase_gen_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_gen_multi.sv
// Multi-channel phase/enable generator: a free-running period counter drives CH
// programmable [rise, fall) windows, with shadowed config applied at period boundaries.
module phase_gen_multi #(
  parameter int                 CH         = 4,
  parameter int                 CW         = 8,
  parameter int                 DEF_PERIOD = 100,
  parameter logic [CH*CW-1:0]   DEF_RISE   = {8'd90, 8'd80, 8'd0, 8'd6},
  parameter logic [CH*CW-1:0]   DEF_FALL   = {8'd0, 8'd0, 8'd50, 8'd70}
) (
  input  logic          clk_100M,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  output logic [CH-1:0] phase_out,
  output logic          period_start,
  output logic [CW-1:0] cnt_o,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          wrap, load_act;

  logic [CW-1:0] sh_period, act_period, nx_period;
  logic [CW-1:0] sh_rise [CH];
  logic [CW-1:0] sh_fall [CH];
  logic [CW-1:0] act_rise [CH];
  logic [CW-1:0] act_fall [CH];
  logic [CW-1:0] nx_rise [CH];
  logic [CW-1:0] nx_fall [CH];

  logic [CH-1:0] phase_nx;
  logic          busy_nx;

  function automatic logic window(input logic [CW-1:0] c, input logic [CW-1:0] r,
                                  input logic [CW-1:0] f, input logic [CW-1:0] p);
    if (r >= p || f > p) return 1'b0;
    if (r < f)           return (c >= r) && (c < f);
    if (r > f)           return (c >= r) || (c < f);
    return 1'b0;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wrap     = (state != S_IDLE) && (cnt == act_period - CW'(1));
    unique case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (run)       state_nx = S_RUN;
        else if (step) state_nx = S_LAST;
      end
      S_RUN: begin
        cnt_nx = wrap ? '0 : cnt + CW'(1);
        if (!run) state_nx = S_LAST;
      end
      S_LAST: begin
        cnt_nx = wrap ? '0 : cnt + CW'(1);
        if (run)       state_nx = S_RUN;
        else if (wrap) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Active config follows shadow while idle and at each wrap, so the window for
  // the first cnt of a period already sees the new values.
  always_comb begin
    load_act  = (state == S_IDLE) || wrap;
    nx_period = load_act ? sh_period : act_period;
    for (int i = 0; i < CH; i++) begin
      nx_rise[i] = load_act ? sh_rise[i] : act_rise[i];
      nx_fall[i] = load_act ? sh_fall[i] : act_fall[i];
    end
  end

  always_comb begin
    busy_nx  = (state_nx != S_IDLE);
    phase_nx = '0;
    for (int i = 0; i < CH; i++)
      phase_nx[i] = busy_nx && window(cnt_nx, nx_rise[i], nx_fall[i], nx_period);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      phase_out    <= '0;
      period_start <= 1'b0;
      act_period   <= CW'(DEF_PERIOD);
      for (int i = 0; i < CH; i++) begin
        act_rise[i] <= DEF_RISE[i*CW +: CW];
        act_fall[i] <= DEF_FALL[i*CW +: CW];
      end
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      phase_out    <= phase_nx;
      period_start <= busy_nx && (cnt_nx == '0);
      act_period   <= nx_period;
      for (int i = 0; i < CH; i++) begin
        act_rise[i] <= nx_rise[i];
        act_fall[i] <= nx_fall[i];
      end
    end
  end

  // Config registers are reset to the defaults because reset must restore them.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      sh_period <= CW'(DEF_PERIOD);
      for (int i = 0; i < CH; i++) begin
        sh_rise[i] <= DEF_RISE[i*CW +: CW];
        sh_fall[i] <= DEF_FALL[i*CW +: CW];
      end
    end else if (cfg_we) begin
      if (cfg_addr == 5'd0)
        sh_period <= (cfg_wdata < CW'(2)) ? CW'(2) : cfg_wdata;
      for (int i = 0; i < CH; i++) begin
        if ({1'b0, cfg_addr} == 6'(i + 1))      sh_rise[i] <= cfg_wdata;
        if ({1'b0, cfg_addr} == 6'(CH + 1 + i)) sh_fall[i] <= cfg_wdata;
      end
    end
  end

  assign cnt_o = cnt;
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_phase_gen_multi.sv
// Directed bench for phase_gen_multi: defaults, reconfig, step, drain, edge configs, reset.
module tb_phase_gen_multi;

  logic       clk_100M = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [3:0] phase_out;
  logic       period_start;
  logic [7:0] cnt_o;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [13:0] obs, exp;

  phase_gen_multi dut (
    .clk_100M     (clk_100M),
    .rst          (rst),
    .run          (run),
    .step         (step),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .phase_out    (phase_out),
    .period_start (period_start),
    .cnt_o        (cnt_o),
    .busy         (busy)
  );

  always #5 clk_100M = ~clk_100M;

  // Hand-transcribed default windows: ch0 6..69, ch1 0..49, ch2 80..99, ch3 90..99.
  function automatic logic [3:0] def_phase(input int c);
    return {c >= 90, c >= 80, c < 50, (c >= 6) && (c < 70)};
  endfunction

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; cfg_we = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    obs = {busy, period_start, cnt_o, phase_out};
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs, 14'd0);
    end
  endtask

  task automatic test_defaults();
    apply_reset();
    run = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      exp = {1'b1, (k % 100) == 0, 8'(k % 100), def_phase(k % 100)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL defaults k=%0d got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_reconfig();
    apply_reset();
    run = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      exp = {1'b1, k == 0, 8'(k), def_phase(k)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reconfig_old k=%0d got %h want %h", k, obs, exp);
      end
      cfg_we = 1'b0;
      if (k == 30) begin cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 8'd20; end
      if (k == 31) begin cfg_we = 1'b1; cfg_addr = 5'd1; cfg_wdata = 8'd2;  end
      if (k == 32) begin cfg_we = 1'b1; cfg_addr = 5'd5; cfg_wdata = 8'd5;  end
    end
    for (int j = 0; j < 40; j++) begin
      tick();
      exp = {1'b1, (j % 20) == 0, 8'(j % 20), 3'b000, ((j % 20) >= 2) && ((j % 20) < 5)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reconfig_new j=%0d got %h want %h", j, obs, exp);
      end
    end
  endtask

  task automatic test_step();
    apply_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) tick();
      exp = {1'b1, k == 0, 8'(k), def_phase(k)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL step k=%0d got %h want %h", k, obs, exp);
      end
      step = (k == 10);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== 14'd0) begin
        errors++;
        $display("FAIL step_idle j=%0d got %h want %h", j, obs, 14'd0);
      end
    end
  endtask

  task automatic test_drain();
    apply_reset();
    run = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      exp = {1'b1, k == 0, 8'(k), def_phase(k)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL drain k=%0d got %h want %h", k, obs, exp);
      end
      if (k == 40) run = 1'b0;
    end
    tick();
    obs = {busy, period_start, cnt_o, phase_out};
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL drain_idle got %h want %h", obs, 14'd0);
    end
    run = 1'b1;
    for (int k = 0; k < 101; k++) begin
      tick();
      exp = {1'b1, (k % 100) == 0, 8'(k % 100), def_phase(k % 100)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rerun k=%0d got %h want %h", k, obs, exp);
      end
      if (k == 40) run = 1'b0;
      if (k == 60) run = 1'b1;
    end
  endtask

  task automatic test_edges();
    apply_reset();
    do_write(5'd0, 8'd0);
    run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp = {1'b1, (k % 2) == 0, 8'(k % 2), 4'b0000};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL period_min k=%0d got %h want %h", k, obs, exp);
      end
    end
    apply_reset();
    do_write(5'd0, 8'd10);
    do_write(5'd1, 8'd5);
    do_write(5'd5, 8'd2);
    do_write(5'd2, 8'd7);
    do_write(5'd6, 8'd7);
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp = {1'b1, (k % 10) == 0, 8'(k % 10), 3'b000, ((k % 10) >= 5) || ((k % 10) < 2)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL edge_wrap k=%0d got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_write(5'd1, 8'd10);
    do_write(5'd0, 8'd60);
    run = 1'b1;
    for (int k = 0; k <= 55; k++) begin
      tick();
      exp = {1'b1, k == 0, 8'(k), 2'b00, k < 50, 1'b0};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pre_reset k=%0d got %h want %h", k, obs, exp);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {busy, period_start, cnt_o, phase_out};
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid got %h want %h", obs, 14'd0);
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      exp = {1'b1, k == 0, 8'(k), def_phase(k)};
      obs = {busy, period_start, cnt_o, phase_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL post_reset k=%0d got %h want %h", k, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reconfig();
    test_step();
    test_drain();
    test_edges();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
